mips_pc_unit: RTL and testbench

Program-counter register and next-PC selector for the single-cycle/multicycle MIPS core.
- Consumes the 28-bit jump target produced by the jump-field shift-left-2 stage, the sign-extended branch offset, and the JR register address.
- Sequences the PC: sequential fetch, redirection, stall hold, and deferred redirects that arrive while stalled.
- Sits between the control/shift logic and the instruction-memory address port.

---
 rtl/mips_pc_unit.sv | 127 ++++++++++++
 tb/tb_mips_pc_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mips_pc_unit.sv
// mips_pc_unit: program-counter register and next-PC selector.
// The PC advances by 4 each cycle unless a jump, branch or JR redirects it.
// A redirect that arrives during a stall is held as a pending target and is
// applied on the first unstalled cycle. A newer redirect replaces a pending
// one, and a redirect present on that first unstalled cycle also wins.
// Optional feature: define PC_REDIRECT_COUNT_EN to add the redirect_count
// output, which counts the redirect targets written into the PC.
// Handshake: there is no valid/ready pair. stall=1 holds the PC for the
// cycle. A redirect enable is consumed on every edge where it is high:
// it is either applied to the PC or latched as the pending target.
module mips_pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [27:0]     jump_target,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            jr_en,
  input  logic [PC_W-1:0] jr_addr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            redirect_pending,
  output logic            addr_misaligned,
  output logic            state_dbg
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [31:0]     redirect_count
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            mis_q, mis_d;
  logic            redirect;
  logic [PC_W-1:0] target;

  assign pc_plus4         = pc_q + 32'd4;
  assign pc               = pc_q;
  assign redirect_pending = (state_q == HOLD);
  assign addr_misaligned  = mis_q;
  assign state_dbg        = state_q;
  assign redirect         = jr_en | jump_en | branch_en;

  // Select the redirect target. JR has the highest priority, then jump,
  // then branch.
  always_comb begin
    target = pc_plus4 + branch_offset;
    if (jr_en) begin
      target = {jr_addr[PC_W-1:2], 2'b00};
    end else if (jump_en) begin
      target = {pc_plus4[PC_W-1:28], jump_target};
    end
  end

  // Next-state logic. The pending target is computed from the PC at the
  // time it is latched, not from the PC when it is applied.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    mis_d   = jr_en & (jr_addr[1:0] != 2'b00);
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          pc_d = redirect ? target : pc_plus4;
        end else if (redirect) begin
          pend_d  = target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (redirect) pend_d = target;
        end else begin
          pc_d    = redirect ? target : pend_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC, pending-target and misaligned-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] count_q;
  logic        count_inc;

  // A redirect target is written into the PC on any unstalled edge that
  // either carries a redirect or leaves HOLD.
  assign count_inc      = !stall && (redirect || (state_q == HOLD));
  assign redirect_count = count_q;

  // Redirect counter. It wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (count_inc) begin
      count_q <= count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_pc_unit.sv
// Bench for mips_pc_unit: directed test-plan steps followed by random
// traffic, all checked against a rule-level reference model.
module tb_mips_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall, jump_en, branch_en, jr_en;
  logic [27:0] jump_target;
  logic [31:0] branch_offset, jr_addr;
  logic [31:0] pc, pc_plus4;
  logic        redirect_pending, addr_misaligned, state_dbg;
`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] redirect_count;
`endif

  mips_pc_unit #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .jump_en          (jump_en),
    .jump_target      (jump_target),
    .branch_en        (branch_en),
    .branch_offset    (branch_offset),
    .jr_en            (jr_en),
    .jr_addr          (jr_addr),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .addr_misaligned  (addr_misaligned),
    .state_dbg        (state_dbg)
`ifdef PC_REDIRECT_COUNT_EN
    ,
    .redirect_count   (redirect_count)
`endif
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: the architectural PC, an optional pending target,
  // the misaligned flag and the redirect count.
  logic [31:0] m_pc, m_pend_t, m_cnt;
  logic        m_pend_v, m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_pend_v = 1'b0;
    m_pend_t = 32'h0;
    m_mis    = 1'b0;
    m_cnt    = 32'h0;
  endtask

  task automatic check_outputs();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend_v});
    check("state_dbg", {31'b0, state_dbg}, {31'b0, m_pend_v});
    check("addr_misaligned", {31'b0, addr_misaligned}, {31'b0, m_mis});
`ifdef PC_REDIRECT_COUNT_EN
    check("redirect_count", redirect_count, m_cnt);
`endif
  endtask

  // Driver: called at posedge+1. It applies the inputs for one cycle,
  // checks the outputs at the negative edge, advances the model and
  // returns at the next posedge+1.
  task automatic cycle(input logic st, input logic je, input logic [27:0] jt,
                       input logic be, input logic [31:0] bo,
                       input logic jre, input logic [31:0] ja);
    logic [31:0] p4, tgt;
    logic        redir;
    stall = st; jump_en = je; jump_target = jt;
    branch_en = be; branch_offset = bo; jr_en = jre; jr_addr = ja;
    @(negedge clk);
    check_outputs();
    p4    = m_pc + 32'd4;
    redir = je | be | jre;
    if (jre)     tgt = {ja[31:2], 2'b00};
    else if (je) tgt = {p4[31:28], jt};
    else         tgt = p4 + bo;
    m_mis = jre && (ja[1:0] != 2'b00);
    if (!st) begin
      if (redir) begin
        m_pc = tgt; m_cnt = m_cnt + 32'd1;
      end else if (m_pend_v) begin
        m_pc = m_pend_t; m_cnt = m_cnt + 32'd1;
      end else begin
        m_pc = p4;
      end
      m_pend_v = 1'b0;
    end else if (redir) begin
      m_pend_v = 1'b1;
      m_pend_t = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    cycle(st, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_jr(input logic [31:0] a);
    cycle(1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b1, a);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; jump_en = 1'b0; jump_target = 28'h0;
    branch_en = 1'b0; branch_offset = 32'h0; jr_en = 1'b0; jr_addr = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc, RESET_PC);
    check("reset_pending", {31'b0, redirect_pending}, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch after reset release: 0, 4, 8, C.
    repeat (4) idle(1'b0);
    check("seq_pc", pc, 32'h10);

    // Jump keeps the upper nibble of pc+4.
    do_jr(32'h0040_0010);
    cycle(1'b0, 1'b1, 28'h010_0020, 1'b0, 32'h0, 1'b0, 32'h0);
    check("tp_jump", pc, 32'h0010_0020);

    // Backward branch relative to pc+4.
    do_jr(32'h0040_0100);
    cycle(1'b0, 1'b0, 28'h0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0);
    check("tp_branch", pc, 32'h0040_00F4);

    // JR beats jump; a misaligned address raises a one-cycle pulse.
    cycle(1'b0, 1'b1, 28'h000_0100, 1'b0, 32'h0, 1'b1, 32'h1000_0007);
    check("tp_jr_pc", pc, 32'h1000_0004);
    check("tp_jr_mis", {31'b0, addr_misaligned}, 32'h1);
    idle(1'b0);
    check("tp_mis_clear", {31'b0, addr_misaligned}, 32'h0);

    // Stalled redirects: the newest one wins when the stall ends.
    do_jr(32'h0000_0020);
    cycle(1'b1, 1'b0, 28'h0, 1'b1, 32'h0000_005C, 1'b0, 32'h0);
    check("tp_hold_pc", pc, 32'h20);
    check("tp_hold_pend", {31'b0, redirect_pending}, 32'h1);
    cycle(1'b1, 1'b1, 28'h000_0400, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b0);
    check("tp_apply_pc", pc, 32'h400);
    check("tp_apply_pend", {31'b0, redirect_pending}, 32'h0);

    // PC wraps from FFFF_FFFC to 0.
    do_jr(32'hFFFF_FFF8);
    repeat (3) idle(1'b0);
    check("wrap_pc", pc, 32'h4);

    // Asynchronous reset in the middle of a HOLD discards the pending target.
    cycle(1'b1, 1'b1, 28'h000_0800, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_hold_pc", pc, RESET_PC);
    check("rst_hold_pend", {31'b0, redirect_pending}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) idle(1'b0);
    check("rst_resume_pc", pc, RESET_PC + 32'hC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 2, 28'($urandom),
            $urandom_range(0, 9) < 2, $urandom,
            $urandom_range(0, 9) < 2, $urandom);
    end
    idle(1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
